// File: rtl/button_pio_debounced.sv
// button_pio_debounced: synchronised, debounced push-buttons with latched press events,
// exposed as an Avalon-MM slave (DATA/MASK/EDGE/COUNT) with a maskable level IRQ.
module button_pio_debounced #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [NUM_CH-1:0] button_external_export,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [NUM_CH-1:0] pressed, sync;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] stable_q, stable_d, prev_q, press;
  logic [NUM_CH-1:0] mask_q, mask_d, edge_q, edge_d, w1c;
  logic [15:0]       count_q, count_d, npress;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              unused_wdata;
  assign unused_wdata = ^avs_writedata;
  assign pressed = (ACTIVE_LOW != 0) ? ~button_external_export : button_external_export;
  assign sync = sync_q[SYNC_STAGES-1];
  // A channel only accepts a new level after it has disagreed for DEBOUNCE_CYCLES in a row.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign cnt_d[c]    = (sync[c] == stable_q[c] || cnt_q[c] == CMAX) ? '0 : cnt_q[c] + CW'(1);
    assign stable_d[c] = (sync[c] != stable_q[c] && cnt_q[c] == CMAX) ? sync[c] : stable_q[c];
  end
  always_comb begin
    press   = stable_q & ~prev_q;
    npress  = '0;
    for (int i = 0; i < NUM_CH; i++) npress = npress + 16'(press[i]);
    mask_d  = (avs_write && avs_address == 2'd1) ? avs_writedata[NUM_CH-1:0] : mask_q;
    w1c     = (avs_write && avs_address == 2'd2) ? avs_writedata[NUM_CH-1:0] : '0;
    edge_d  = (edge_q & ~w1c) | press;
    count_d = ((avs_write && avs_address == 2'd3) ? 16'd0 : count_q) + npress;
    irq_d   = |(edge_d & mask_d);
    rdata_d = !avs_read ? rdata_q :
              avs_address == 2'd0 ? 32'(stable_q) :
              avs_address == 2'd1 ? 32'(mask_q) :
              avs_address == 2'd2 ? 32'(edge_q) : 32'(count_q);
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_q[0] <= pressed;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
      stable_q <= stable_d;
      prev_q   <= stable_q;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end
  assign avs_readdata = rdata_q;
  assign avs_irq      = irq_q;
endmodule
